// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline definitions: opcode constants, instruction field ranges, register index type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipeline_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [6:0] opcode_t;

    // Base opcodes (instruction bits [6:0])
    localparam opcode_t OP_R      = 7'h33;
    localparam opcode_t OP_IMM    = 7'h13;
    localparam opcode_t OP_LOAD   = 7'h03;
    localparam opcode_t OP_STORE  = 7'h23;
    localparam opcode_t OP_BRANCH = 7'h63;
    localparam opcode_t OP_JALR   = 7'h67;
    localparam opcode_t OP_LUI    = 7'h37;
    localparam opcode_t OP_AUIPC  = 7'h17;
    localparam opcode_t OP_JAL    = 7'h6F;

    // Instruction field bit ranges
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;

endpackage

// File: rtl/hazard_src_decode.sv
// Source-operand usage decode: which of rs1/rs2 an opcode actually reads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output tracks input.
//
// Ports:
//   opcode   - instruction bits [6:0]
//   uses_rs1 - instruction reads rs1 (R, I-ALU, load, store, branch, JALR)
//   uses_rs2 - instruction reads rs2 (R, store, branch)
// Shared with the forwarding unit so both agree on operand usage.
module hazard_src_decode
    import pipeline_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                uses_rs1 = 1'b1;
            end
            // LUI, AUIPC, JAL and anything unrecognised read no registers
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_u.sv
// Load-use hazard detection for the ID stage: stalls PC and IF/ID, bubbles ID/EX.
// Latency: SignalPC/IFID_Write/Ctrl_Flush combinational (0 cycles); stall_q/stall_cnt registered (1 cycle).
// Backpressure: produces the stall itself; holds it for as long as the load in ID/EX matches a used source.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (only affects stall_q/stall_cnt)
//   R_d, MemRead  - destination and load flag of the instruction in ID/EX
//   Instruction   - raw instruction word in IF/ID
//   SignalPC      - 1 = hold PC; IFID_Write = ~SignalPC; Ctrl_Flush = SignalPC
//   stall_q       - SignalPC delayed by one cycle
//   stall_cnt     - saturating stall-cycle counter, only when HAZARD_U_PERF_CNT_EN is defined
// Optional feature macro: HAZARD_U_PERF_CNT_EN
module hazard_u
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       R_d,
    input  logic             MemRead,
    input  logic [31:0]      Instruction,
    output logic             SignalPC,
    output logic             IFID_Write,
    output logic             Ctrl_Flush,
    output logic             stall_q
`ifdef HAZARD_U_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    reg_idx_t   w_rs1;
    reg_idx_t   w_rs2;
    opcode_t    w_opcode;
    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_stall;
    logic       w_unused_bits;
    logic       r_stall_q;

    assign w_opcode = Instruction[OPCODE_MSB:OPCODE_LSB];
    assign w_rs1    = Instruction[RS1_MSB:RS1_LSB];
    assign w_rs2    = Instruction[RS2_MSB:RS2_LSB];

    // funct/immediate/rd fields play no part in hazard detection
    assign w_unused_bits = ^{Instruction[31:25], Instruction[14:7]};

    hazard_src_decode u_src_decode (
        .opcode   (w_opcode),
        .uses_rs1 (w_uses_rs1),
        .uses_rs2 (w_uses_rs2)
    );

    assign w_rs1_hit = w_uses_rs1 && (w_rs1 == R_d);
    assign w_rs2_hit = w_uses_rs2 && (w_rs2 == R_d);

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign w_stall = MemRead && (R_d != 5'd0) && (w_rs1_hit || w_rs2_hit);

    assign SignalPC   = w_stall;
    assign IFID_Write = ~w_stall;
    assign Ctrl_Flush = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_q <= 1'b0;
        end else begin
            r_stall_q <= w_stall;
        end
    end

    assign stall_q = r_stall_q;

`ifdef HAZARD_U_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturates at all-ones so a long run never reads back as a small count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_u.sv
// Self-checking bench for hazard_u: directed vectors plus randomized stimulus vs a reference model.
// Latency: combinational outputs checked 1 time unit after input change; registered ones 1 unit after posedge.
// Backpressure: n/a.
module tb_hazard_u;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic [4:0]  R_d;
    logic        MemRead;
    logic [31:0] Instruction;
    logic        SignalPC;
    logic        IFID_Write;
    logic        Ctrl_Flush;
    logic        stall_q;
`ifdef HAZARD_U_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_checks;
    int n_errors;

    // Reference model state
    int m_q;
    int m_cnt;

    hazard_u #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .R_d         (R_d),
        .MemRead     (MemRead),
        .Instruction (Instruction),
        .SignalPC    (SignalPC),
        .IFID_Write  (IFID_Write),
        .Ctrl_Flush  (Ctrl_Flush),
        .stall_q     (stall_q)
`ifdef HAZARD_U_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Specification-level model of the stall condition
    function automatic logic ref_stall(input logic [4:0] rd, input logic mr, input logic [31:0] ins);
        int op;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        op  = int'(ins) & 32'h7F;
        rs1 = (int'(ins) >> 15) & 32'h1F;
        rs2 = (int'(ins) >> 20) & 32'h1F;
        u1  = (op == 'h33) || (op == 'h13) || (op == 'h03) || (op == 'h23) ||
              (op == 'h63) || (op == 'h67);
        u2  = (op == 'h33) || (op == 'h23) || (op == 'h63);
        return mr && (int'(rd) != 0) && ((u1 && rs1 == int'(rd)) || (u2 && rs2 == int'(rd)));
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_stall_q"}, 32'(stall_q), 32'(m_q));
`ifdef HAZARD_U_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, check registers
    task automatic step(input string tag, input logic [4:0] rd, input logic mr,
                        input logic [31:0] ins, input logic exp);
        @(negedge clk);
        R_d = rd;
        MemRead = mr;
        Instruction = ins;
        #1;
        chk({tag, "_SignalPC"},   32'(SignalPC),   32'(exp));
        chk({tag, "_IFID_Write"}, 32'(IFID_Write), 32'(!exp));
        chk({tag, "_Ctrl_Flush"}, 32'(Ctrl_Flush), 32'(exp));
        @(posedge clk);
        m_q = exp ? 1 : 0;
        if (exp && m_cnt < CNT_MAX) m_cnt++;
        #1;
        check_regs(tag);
    endtask

    // Reset pulse asserted mid-cycle with current inputs left in place
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_q = 0;
        m_cnt = 0;
        check_regs(tag);
        chk({tag, "_SignalPC"}, 32'(SignalPC), 32'(ref_stall(R_d, MemRead, Instruction)));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]  ops [12];
        logic [31:0] ins;
        logic [4:0]  rd;
        logic        mr;
        int          sel;

        n_checks = 0;
        n_errors = 0;
        m_q = 0;
        m_cnt = 0;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67,
                7'h37, 7'h17, 7'h6F, 7'h00, 7'h73, 7'h0F};

        // Reset state; combinational path must follow inputs even during reset
        rst_n = 1'b0;
        R_d = 5'd0;
        MemRead = 1'b0;
        Instruction = 32'h0;
        #3;
        check_regs("reset");
        chk("reset_SignalPC_idle", 32'(SignalPC), 32'd0);
        R_d = 5'd4;
        MemRead = 1'b1;
        Instruction = 32'h8A620013;
        #1;
        chk("reset_SignalPC_stall", 32'(SignalPC), 32'd1);
        chk("reset_IFID_Write", 32'(IFID_Write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        step("imm_nohit",  5'd10, 1'b1, 32'h8A620013, 1'b0);
        step("imm_rs1hit", 5'd4,  1'b1, 32'h8A620013, 1'b1);
        step("imm_rs2ign", 5'd6,  1'b1, 32'h8A620013, 1'b0);
        step("add_rs2hit", 5'd10, 1'b1, 32'h00A48033, 1'b1);
        step("add_noload", 5'd10, 1'b0, 32'h00A48033, 1'b0);
        step("x0_dest",    5'd0,  1'b1, 32'h00000033, 1'b0);
        step("lui",        5'd5,  1'b1, 32'h002852B7, 1'b0);
        step("store_rs2",  5'd7,  1'b1, 32'h0071A023, 1'b1);
        step("jal",        5'd1,  1'b1, 32'h0010806F, 1'b0);

        // Counter over three held stall cycles, then a mid-cycle reset while stalling
        mid_reset("rst_a");
        step("hold1", 5'd4, 1'b1, 32'h8A620013, 1'b1);
        step("hold2", 5'd4, 1'b1, 32'h8A620013, 1'b1);
        step("hold3", 5'd4, 1'b1, 32'h8A620013, 1'b1);
`ifdef HAZARD_U_PERF_CNT_EN
        chk("hold3_cnt_abs", 32'(stall_cnt), 32'd3);
`endif
        chk("hold3_q_abs", 32'(stall_q), 32'd1);
        mid_reset("rst_mid");

        // Saturation: more stall cycles than the counter can hold
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            step("sat", 5'd4, 1'b1, 32'h8A620013, 1'b1);
        end
`ifdef HAZARD_U_PERF_CNT_EN
        chk("sat_cnt_abs", 32'(stall_cnt), 32'(CNT_MAX));
`endif

        // Randomized stimulus against the reference model
        mid_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rd = ins[19:15];
                1:       rd = ins[24:20];
                2:       rd = 5'd0;
                default: rd = 5'($urandom);
            endcase
            mr = ($urandom_range(0, 3) != 0);
            step("rand", rd, mr, ins, ref_stall(rd, mr, ins));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
